// File: rtl/round_sat.sv
// Streaming fixed-point requantiser: rounds away SHIFT LSBs with a run-time mode,
// then narrows to OWID bits with saturation or wrap. Two-stage pipeline, valid/ready.
module round_sat #(
  parameter int IWID     = 16,
  parameter int SHIFT    = 8,
  parameter int OWID     = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [IWID-1:0] i_data,
  input  logic [2:0]      i_mode,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [OWID-1:0] o_data,
  output logic            o_ovfl,
  input  logic            i_clr_count,
  output logic [15:0]     o_ovfl_count
);

  localparam int RWID = IWID - SHIFT + 1;

  localparam logic [IWID:0] HALF    = {{(IWID-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic [IWID:0] HALF_M1 = HALF - {{IWID{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    MODE_TRUNC      = 3'd0,
    MODE_HALF_UP    = 3'd1,
    MODE_HALF_DOWN  = 3'd2,
    MODE_TO_ZERO    = 3'd3,
    MODE_FROM_ZERO  = 3'd4,
    MODE_CONVERGENT = 3'd5
  } mode_e;

  logic                   ce;
  logic        [IWID:0]   bias;
  logic signed [IWID:0]   sum;
  logic        [RWID-1:0] rnd;

  logic                   s1_valid;
  logic        [RWID-1:0] s1_r;
  logic                   s1_sign;

  logic [RWID-OWID:0]     r_top;
  logic                   r_ovf;
  logic [OWID-1:0]        r_out;

  assign ce      = !o_valid || i_ready;
  assign o_ready = ce;

  always_comb begin
    bias = '0;
    case (mode_e'(i_mode))
      MODE_TRUNC:      bias = '0;
      MODE_HALF_UP:    bias = HALF;
      MODE_HALF_DOWN:  bias = HALF_M1;
      MODE_TO_ZERO:    bias = i_data[IWID-1] ? HALF : HALF_M1;
      MODE_FROM_ZERO:  bias = i_data[IWID-1] ? HALF_M1 : HALF;
      MODE_CONVERGENT: bias = i_data[SHIFT] ? HALF : HALF_M1;
      default:         bias = '0;
    endcase
    sum = $signed({i_data[IWID-1], i_data}) + $signed(bias);
    rnd = RWID'(sum >>> SHIFT);
  end

  // A negative input can only round to R <= 0 and a non-negative one to R >= 0,
  // so the registered input sign picks the saturation rail.
  always_comb begin
    r_top = s1_r[RWID-1:OWID-1];
    r_ovf = !((&r_top) || !(|r_top));
    r_out = s1_r[OWID-1:0];
    if (SATURATE && r_ovf)
      r_out = s1_sign ? {1'b1, {(OWID-1){1'b0}}} : {1'b0, {(OWID-1){1'b1}}};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_sign  <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_ovfl   <= 1'b0;
    end else if (ce) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_r    <= rnd;
        s1_sign <= i_data[IWID-1];
      end
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_data <= r_out;
        o_ovfl <= r_ovf;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      o_ovfl_count <= '0;
    else if (i_clr_count)
      o_ovfl_count <= '0;
    else if (o_valid && i_ready && o_ovfl && (o_ovfl_count != 16'hFFFF))
      o_ovfl_count <= o_ovfl_count + 16'd1;
  end

endmodule
